lvds_tx_initialization: RTL



---
 rtl/lvds_tx_pkg.sv | 9 +
 rtl/lvds_lock_filter.sv | 30 +++
 rtl/lvds_tx_initialization.sv | 78 +++++++
 3 files changed

// File: rtl/lvds_tx_pkg.sv
// lvds_tx_pkg: shared state type, default lane words and counter sizing for the LVDS TX init sequencer
package lvds_tx_pkg;
   typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, TRAIN, RUN} tx_init_state_t;
   localparam logic [9:0] DEF_TRAIN_WORD = 10'b1010101010;
   localparam logic [9:0] DEF_IDLE_WORD  = 10'b0000011111;
   function automatic int cnt_w(input int max);
      return $clog2(max + 1);
   endfunction
endpackage

// File: rtl/lvds_lock_filter.sv
// lvds_lock_filter: counts consecutive locked samples and total wait cycles while enabled
module lvds_lock_filter
   import lvds_tx_pkg::*;
#(
   parameter int STABLE_CYCLES  = 20,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic inclock,
   input  logic reset_n,
   input  logic en,
   input  logic locked,
   output logic stable,
   output logic timeout
);
   localparam int SW = cnt_w(STABLE_CYCLES);
   localparam int TW = cnt_w(TIMEOUT_CYCLES);
   logic [SW-1:0] scnt;
   logic [TW-1:0] tcnt;
   // both counters saturate at their targets so a long wait never wraps
   always_ff @(posedge inclock)
      if (!reset_n || !en) begin
         scnt <= '0;
         tcnt <= '0;
      end else begin
         scnt <= !locked ? '0 : stable ? scnt : scnt + SW'(1);
         tcnt <= timeout ? tcnt : tcnt + TW'(1);
      end
   assign stable  = scnt == SW'(STABLE_CYCLES);
   assign timeout = tcnt == TW'(TIMEOUT_CYCLES);
endmodule

// File: rtl/lvds_tx_initialization.sv
// lvds_tx_initialization: PLL reset, lock qualification and DPA training sequencer in front of the LVDS TX core
module lvds_tx_initialization
   import lvds_tx_pkg::*;
#(
   parameter int SER_FACTOR = 10,
   parameter int CHANNELS = 1,
   parameter logic [SER_FACTOR-1:0] TRAIN_WORD = SER_FACTOR'(DEF_TRAIN_WORD),
   parameter logic [SER_FACTOR-1:0] IDLE_WORD = SER_FACTOR'(DEF_IDLE_WORD),
   parameter int PLL_RST_CYCLES = 4,
   parameter int LOCK_STABLE_CYCLES = 20,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int TRAIN_CYCLES = 256
) (
   input  logic                           inclock,
   input  logic                           reset_n,
   input  logic                           tx_locked,
   input  logic                           retrain,
   input  logic [CHANNELS*SER_FACTOR-1:0] data_in,
   input  logic                           data_valid,
   output logic                           data_ready,
   output logic                           tx_pll_areset,
   output logic [CHANNELS*SER_FACTOR-1:0] tx_in,
   output logic                           link_up,
   output logic                           lock_lost
);
   localparam int W = CHANNELS * SER_FACTOR;
   localparam int CW = cnt_w(PLL_RST_CYCLES > TRAIN_CYCLES ? PLL_RST_CYCLES : TRAIN_CYCLES);
   tx_init_state_t state, next;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [W-1:0] word_nxt;
   logic locked_q, stable, timeout;
   lvds_lock_filter #(
      .STABLE_CYCLES (LOCK_STABLE_CYCLES),
      .TIMEOUT_CYCLES(LOCK_TIMEOUT)
   ) u_filter (
      .inclock(inclock),
      .reset_n(reset_n),
      .en     (next == WAIT_LOCK),
      .locked (locked_q),
      .stable (stable),
      .timeout(timeout)
   );
   always_comb begin
      next = state;
      case (state)
         PLL_RST:   next = cnt == CW'(PLL_RST_CYCLES - 1) ? WAIT_LOCK : PLL_RST;
         WAIT_LOCK: next = stable ? TRAIN : timeout ? PLL_RST : WAIT_LOCK;
         TRAIN:     next = !locked_q ? PLL_RST : (cnt == CW'(TRAIN_CYCLES - 1) && !retrain) ? RUN : TRAIN;
         RUN:       next = !locked_q ? PLL_RST : retrain ? TRAIN : RUN;
         default:   next = PLL_RST;
      endcase
      cnt_nxt = (next == state && (state == PLL_RST || (state == TRAIN && !retrain))) ? cnt + CW'(1) : '0;
      // a word accepted by the previous data_ready is always sent, even if the state is leaving RUN
      word_nxt = (data_ready && data_valid) ? data_in :
                 next == RUN   ? {CHANNELS{IDLE_WORD}} :
                 next == TRAIN ? {CHANNELS{TRAIN_WORD}} : '0;
   end
   always_ff @(posedge inclock)
      if (!reset_n) begin
         state         <= PLL_RST;
         cnt           <= '0;
         locked_q      <= 1'b0;
         tx_pll_areset <= 1'b1;
         tx_in         <= '0;
         data_ready    <= 1'b0;
         link_up       <= 1'b0;
         lock_lost     <= 1'b0;
      end else begin
         state         <= next;
         cnt           <= cnt_nxt;
         locked_q      <= tx_locked;
         tx_pll_areset <= next == PLL_RST;
         tx_in         <= word_nxt;
         data_ready    <= next == RUN && tx_locked;
         link_up       <= next == RUN;
         lock_lost     <= (state == TRAIN || state == RUN) && !locked_q;
      end
endmodule
